// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch-side inputs, write-back port, hazard stall and ID/EX outputs.
// The master side drives fetch/write-back; the slave side is the decode stage.
interface decode_stage_if;
  logic [15:0] instr;
  logic [15:0] pcIn;
  logic        flush;
  logic        wbEn;
  logic [2:0]  wbReg;
  logic [15:0] wbData;
  logic        stall;
  logic [15:0] exInstr;
  logic [15:0] exPc;
  logic [15:0] exRsData;
  logic [15:0] exRtData;
  logic [15:0] exImm;
  logic [2:0]  exDest;
  logic        exRegWrite;
  logic        exMemRead;
  logic        halt;

  modport master (
    output instr, pcIn, flush, wbEn, wbReg, wbData,
    input  stall, exInstr, exPc, exRsData, exRtData, exImm, exDest, exRegWrite, exMemRead,
           halt
  );

  modport slave (
    input  instr, pcIn, flush, wbEn, wbReg, wbData,
    output stall, exInstr, exPc, exRsData, exRtData, exImm, exDest, exRegWrite, exMemRead,
           halt
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: register file with write-first bypass, load-use hazard detection,
// immediate/control decode and the ID/EX pipeline register with sticky halt.
module decode_stage (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam logic [15:0] NopInstr = 16'h0800;

  logic [4:0] op;
  logic [2:0] rs, rt, rd;

  logic [15:0] regFile [8];

  logic [15:0] rsData, rtData, imm;
  logic [2:0]  dest;
  logic        regWrite, memRead;
  logic        isHalt, bubble, stall;

  logic [15:0] exInstrQ, exPcQ, exRsDataQ, exRtDataQ, exImmQ;
  logic [2:0]  exDestQ;
  logic        exRegWriteQ, exMemReadQ, haltQ, haltD;

  assign op = bus.instr[15:11];
  assign rs = bus.instr[10:8];
  assign rt = bus.instr[7:5];
  assign rd = bus.instr[4:2];

  // Write-first bypass so a same-cycle write-back is seen by the instruction being decoded.
  assign rsData = (bus.wbEn && bus.wbReg == rs) ? bus.wbData : regFile[rs];
  assign rtData = (bus.wbEn && bus.wbReg == rt) ? bus.wbData : regFile[rt];

  always_comb begin
    dest     = 3'd0;
    regWrite = 1'b0;
    memRead  = 1'b0;
    casez (op)
      5'b11001, 5'b11011, 5'b11010, 5'b111??: begin
        dest     = rd;
        regWrite = 1'b1;
      end
      5'b10000: dest = rt;
      5'b10011: begin
        dest     = rs;
        regWrite = 1'b1;
      end
      5'b10001: begin
        dest     = rt;
        regWrite = 1'b1;
        memRead  = 1'b1;
      end
      5'b010??, 5'b101??: begin
        dest     = rt;
        regWrite = 1'b1;
      end
      5'b11000, 5'b10010: begin
        dest     = rs;
        regWrite = 1'b1;
      end
      5'b00110, 5'b00111: begin
        dest     = 3'd7;
        regWrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = {{11{bus.instr[4]}}, bus.instr[4:0]};
    casez (op)
      5'b00100, 5'b00110: imm = {{5{bus.instr[10]}}, bus.instr[10:0]};
      5'b00101, 5'b00111, 5'b011??, 5'b11000, 5'b10010:
        imm = {{8{bus.instr[7]}}, bus.instr[7:0]};
      5'b01010, 5'b01011: imm = {11'd0, bus.instr[4:0]};
      default: ;
    endcase
  end

  // rs/rt are compared for every opcode: false stalls are harmless, missed ones are not.
  assign stall = rst & ~bus.flush & ~haltQ & exMemReadQ & exRegWriteQ &
                 ((exDestQ == rs) | (exDestQ == rt));

  assign isHalt = (op == 5'b00000);
  assign bubble = bus.flush | stall | haltQ | isHalt;
  assign haltD  = haltQ | (isHalt & ~bus.flush & ~stall);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regFile[i] <= 16'd0;
    end else if (bus.wbEn) begin
      regFile[bus.wbReg] <= bus.wbData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bubble) begin
      exInstrQ    <= NopInstr;
      exPcQ       <= 16'd0;
      exRsDataQ   <= 16'd0;
      exRtDataQ   <= 16'd0;
      exImmQ      <= 16'd0;
      exDestQ     <= 3'd0;
      exRegWriteQ <= 1'b0;
      exMemReadQ  <= 1'b0;
    end else begin
      exInstrQ    <= bus.instr;
      exPcQ       <= bus.pcIn;
      exRsDataQ   <= rsData;
      exRtDataQ   <= rtData;
      exImmQ      <= imm;
      exDestQ     <= dest;
      exRegWriteQ <= regWrite;
      exMemReadQ  <= memRead;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) haltQ <= 1'b0;
    else      haltQ <= haltD;
  end

  assign bus.stall      = stall;
  assign bus.exInstr    = exInstrQ;
  assign bus.exPc       = exPcQ;
  assign bus.exRsData   = exRsDataQ;
  assign bus.exRtData   = exRtDataQ;
  assign bus.exImm      = exImmQ;
  assign bus.exDest     = exDestQ;
  assign bus.exRegWrite = exRegWriteQ;
  assign bus.exMemRead  = exMemReadQ;
  assign bus.halt       = haltQ;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: each vector pushes its expected ID/EX contents,
// which are popped and compared one edge later; stall is checked combinationally.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;

  decode_stage_if bus ();

  decode_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] rsData;
    logic [15:0] rtData;
    logic [15:0] imm;
    logic [2:0]  dest;
    logic        regWrite;
    logic        memRead;
    logic        halt;
  } exp_t;

  exp_t sbQ[$];
  int   nVec = 0;
  int   nMis = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic [15:0] instr, input logic [15:0] pc,
                              input logic [15:0] rsD, input logic [15:0] rtD,
                              input logic [15:0] imm, input logic [2:0] dest,
                              input logic rw, input logic mr, input logic hlt);
    exp_t e;
    e.instr = instr; e.pc = pc; e.rsData = rsD; e.rtData = rtD; e.imm = imm;
    e.dest = dest; e.regWrite = rw; e.memRead = mr; e.halt = hlt;
    return e;
  endfunction

  function automatic exp_t bub(input logic hlt);
    return ex(16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, hlt);
  endfunction

  task automatic compareHead();
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      check("exInstr", bus.exInstr, e.instr);
      check("exPc", bus.exPc, e.pc);
      check("exRsData", bus.exRsData, e.rsData);
      check("exRtData", bus.exRtData, e.rtData);
      check("exImm", bus.exImm, e.imm);
      check("exDest", {13'd0, bus.exDest}, {13'd0, e.dest});
      check("exRegWrite", {15'd0, bus.exRegWrite}, {15'd0, e.regWrite});
      check("exMemRead", {15'd0, bus.exMemRead}, {15'd0, e.memRead});
      check("halt", {15'd0, bus.halt}, {15'd0, e.halt});
    end
  endtask

  task automatic apply(input logic r, input logic [15:0] instr, input logic [15:0] pc,
                       input logic fl, input logic we, input logic [2:0] wr,
                       input logic [15:0] wd, input logic expStall, input exp_t e);
    @(negedge clk);
    compareHead();
    rst = r;
    bus.instr = instr; bus.pcIn = pc; bus.flush = fl;
    bus.wbEn = we; bus.wbReg = wr; bus.wbData = wd;
    #1;
    check("stall", {15'd0, bus.stall}, {15'd0, expStall});
    sbQ.push_back(e);
  endtask

  initial begin
    bus.instr = 16'h0800; bus.pcIn = 16'h0; bus.flush = 1'b0;
    bus.wbEn = 1'b0; bus.wbReg = 3'd0; bus.wbData = 16'h0;

    // Reset with a write-back pending: reset must win.
    apply(0, 16'hDB64, 16'h0002, 0, 1, 3'd3, 16'hFFFF, 0, bub(0));
    apply(0, 16'hDB64, 16'h0002, 0, 1, 3'd3, 16'hFFFF, 0, bub(0));
    apply(1, 16'hDB64, 16'h0002, 0, 0, 3'd0, 16'h0,    0,
          ex(16'hDB64, 16'h0002, 16'h0, 16'h0, 16'h0004, 3'd1, 1, 0, 0));
    // Same-cycle write-back bypass on rs, then on rt with R0.
    apply(1, 16'hDA14, 16'h0004, 0, 1, 3'd2, 16'h1234, 0,
          ex(16'hDA14, 16'h0004, 16'h1234, 16'h0, 16'hFFF4, 3'd5, 1, 0, 0));
    apply(1, 16'hDA18, 16'h0006, 0, 1, 3'd0, 16'h00AA, 0,
          ex(16'hDA18, 16'h0006, 16'h1234, 16'h00AA, 16'hFFF8, 3'd6, 1, 0, 0));
    // Load-use: LD R4 then ADD reading R4.
    apply(1, 16'h8980, 16'h0008, 0, 1, 3'd1, 16'h0100, 0,
          ex(16'h8980, 16'h0008, 16'h0100, 16'h0, 16'h0, 3'd4, 1, 1, 0));
    apply(1, 16'hDA8C, 16'h000A, 0, 1, 3'd4, 16'h5555, 1, bub(0));
    apply(1, 16'hDA8C, 16'h000A, 0, 0, 3'd0, 16'h0,    0,
          ex(16'hDA8C, 16'h000A, 16'h1234, 16'h5555, 16'h000C, 3'd3, 1, 0, 0));
    // Flush beats the would-be stall.
    apply(1, 16'h8980, 16'h000C, 0, 0, 3'd0, 16'h0, 0,
          ex(16'h8980, 16'h000C, 16'h0100, 16'h5555, 16'h0, 3'd4, 1, 1, 0));
    apply(1, 16'hDA8C, 16'h000E, 1, 0, 3'd0, 16'h0, 0, bub(0));
    // Reset during a would-be stall clears the pipeline and register file.
    apply(1, 16'h8980, 16'h0010, 0, 0, 3'd0, 16'h0, 0,
          ex(16'h8980, 16'h0010, 16'h0100, 16'h5555, 16'h0, 3'd4, 1, 1, 0));
    apply(0, 16'hDA8C, 16'h0012, 0, 0, 3'd0, 16'h0, 0, bub(0));
    apply(1, 16'hDA8C, 16'h0012, 0, 0, 3'd0, 16'h0, 0,
          ex(16'hDA8C, 16'h0012, 16'h0, 16'h0, 16'h000C, 3'd3, 1, 0, 0));
    // Immediate forms and destinations.
    apply(1, 16'hC580, 16'h0014, 0, 0, 3'd0, 16'h0, 0,
          ex(16'hC580, 16'h0014, 16'h0, 16'h0, 16'hFF80, 3'd5, 1, 0, 0));
    apply(1, 16'h595F, 16'h0016, 0, 0, 3'd0, 16'h0, 0,
          ex(16'h595F, 16'h0016, 16'h0, 16'h0, 16'h001F, 3'd2, 1, 0, 0));
    apply(1, 16'h3400, 16'h0018, 0, 0, 3'd0, 16'h0, 0,
          ex(16'h3400, 16'h0018, 16'h0, 16'h0, 16'hFC00, 3'd7, 1, 0, 0));
    apply(1, 16'h8143, 16'h001A, 0, 1, 3'd1, 16'h7777, 0,
          ex(16'h8143, 16'h001A, 16'h7777, 16'h0, 16'h0003, 3'd2, 0, 0, 0));
    apply(1, 16'h9B3E, 16'h001C, 0, 0, 3'd0, 16'h0, 0,
          ex(16'h9B3E, 16'h001C, 16'h0, 16'h7777, 16'hFFFE, 3'd3, 1, 0, 0));
    apply(1, 16'h967F, 16'h001E, 0, 0, 3'd0, 16'h0, 0,
          ex(16'h967F, 16'h001E, 16'h0, 16'h0, 16'h007F, 3'd6, 1, 0, 0));
    // HALT: bubble plus sticky halt through ten following ALU instructions.
    apply(1, 16'h0000, 16'h0020, 0, 0, 3'd0, 16'h0, 0, bub(1));
    for (int i = 0; i < 10; i++) begin
      apply(1, 16'hDA8C, 16'h0022 + 16'(2 * i), 0, 0, 3'd0, 16'h0, 0, bub(1));
    end
    apply(0, 16'hDA8C, 16'h0000, 0, 0, 3'd0, 16'h0, 0, bub(0));
    apply(1, 16'hDA8C, 16'h0002, 0, 0, 3'd0, 16'h0, 0,
          ex(16'hDA8C, 16'h0002, 16'h0, 16'h0, 16'h000C, 3'd3, 1, 0, 0));

    @(negedge clk);
    compareHead();
    check("sbEmpty", 16'(sbQ.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the 5-stage 16-bit pipeline, directly downstream of the fetch stage. Takes the fetched instruction and its PC+2 from the fetch stage's output flops. It owns the 8x16 register file and the load-use hazard detector, which drives the fetch stage's `stall` input. It also owns the ID/EX pipeline register that feeds execute. Write-back writes into this block through a dedicated port.

## Interface
No parameters; the ISA is fixed.

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset (`rst==0` resets on the next rising edge)
- `instr`  in  16  instruction from fetch (0x0800 = NOP bubble, opcode 00000 = HALT)
- `pcIn`  in  16  PC+2 of `instr`, from fetch
- `flush`  in  1  branch/jump taken; current `instr` is squashed
- `wbEn`  in  1  register-file write enable from write-back
- `wbReg`  in  3  write-back destination
- `wbData`  in  16  write-back data
- `stall`  out  1  combinational load-use stall to fetch
- `exInstr`  out  16  registered instruction
- `exPc`  out  16  registered PC+2
- `exRsData`  out  16  registered R[instr[10:8]]
- `exRtData`  out  16  registered R[instr[7:5]]
- `exImm`  out  16  registered extended immediate
- `exDest`  out  3  registered destination register
- `exRegWrite`  out  1  registered write enable
- `exMemRead`  out  1  registered load flag
- `halt`  out  1  registered, sticky halt

## Operation
**Fields.** `op=instr[15:11]`, `rs=instr[10:8]`, `rt=instr[7:5]`, `rd=instr[4:2]`.

**Destination and write enable (decided from `op`):**
- 11001, 11011, 11010, 111xx: `rd`, write
- 010xx, 101xx, 10000: `rt`; write except 10000 (ST) and 10011 (STU); STU writes `rs`
- 10001 (LD): `rt`, write, `exMemRead=1`
- 11000 (LBI), 10010 (SLBI): `rs`, write
- 00110 (JAL), 00111 (JALR): 7, write
- all others: `exDest=0`, no write

**Immediate (`exImm`):**
- 00100, 00110: sign-extended `instr[10:0]`
- 00101, 00111, 011xx, 11000, 10010: sign-extended `instr[7:0]`
- 01010, 01011: zero-extended `instr[4:0]`
- otherwise: sign-extended `instr[4:0]`

**Register file.**
- 8 x 16 registers; R0 is an ordinary register.
- Write occurs on the clock edge when `wbEn`.
- Reads are combinational with write-first bypass: if `wbEn` and `wbReg` matches the read index, the read returns `wbData` in the same cycle.

**Hazard.**
- `stall = rst & ~flush & ~halt & exMemRead & exRegWrite & (exDest==rs | exDest==rt)`.
- The compare uses `rs`/`rt` for every opcode. False stalls are accepted; missed stalls are not.

**ID/EX update, in priority order each edge:**
1. `rst==0`: all outputs reset.
2. `flush | stall | halt`: load a bubble.
3. Otherwise: load decoded `instr`, `pcIn`, read data, and control.
- Bubble: `exInstr=0x0800`, `exRegWrite=0`, `exMemRead=0`, `exDest=0`, data/imm/pc = 0.

**Halt.**
- `halt` sets when `op==00000`, `~flush`, `~stall`, `halt==0`.
- It stays 1 until reset.
- The HALT instruction itself is passed down as a bubble.

## Timing
- Reset values: `exInstr=0x0800`; `exPc`, `exRsData`, `exRtData`, `exImm`, `exDest` = 0; `exRegWrite=0`, `exMemRead=0`, `halt=0`; all registers = 0; `stall=0` while `rst==0`.
- Latency: `instr` at edge N appears on `ex*` after edge N+1; `halt` rises one edge after HALT is decoded.
- Stall lasts exactly 1 cycle per load-use pair. Next cycle, `exMemRead=0` (bubble), so `stall` drops and the held instruction proceeds.
- `flush` with a would-be stall: `flush` wins, `stall=0`, bubble loaded.
- Write-back to a register being read in the same cycle: new value captured into `exRsData`/`exRtData`.
- Reset asserted mid-stall: `stall` drops immediately (combinational), state cleared at the edge.
- `wbEn` while reset is asserted: ignored; reset wins.

## Test plan
- **Reset.** Hold `rst=0` 2 cycles with `wbEn=1`, `wbReg=3`, `wbData=0xFFFF`. Then drive ADD R1=R3+R3. Expect `exInstr=0x0800` during reset and `exRsData=0` after.
- **Bypass.** Write R2=0x1234 with `wbEn` in the same cycle as `instr` reads `rs=2`. Expect `exRsData=0x1234` next cycle.
- **Load-use.** LD R4,[R1] followed by ADD with `rt=4`. Expect `stall=1` for 1 cycle, a bubble 0x0800 in ID/EX, then the ADD with `exDest=rd`.
- **Flush priority.** Same LD-use pair with `flush=1` in the stall cycle. Expect `stall=0` and a bubble.
- **Immediates.** LBI `rs=5`, imm 0x80: `exImm=0xFF80`, `exDest=5`. ANDNI imm 0x1F: `exImm=0x001F`. JAL imm 0x400: `exImm=0xFC00`, `exDest=7`.
- **Halt.** `instr=0x0000`. Expect `halt=1` next edge and still 1 ten cycles later with ALU instructions input. `ex*` outputs show bubbles.
